// File: rtl/alu_issue4_pkg.sv
// alu_issue_pkg: shared encodings for the 4-bit ALU issue front end.
//   op codes, condition codes, FSM state enum and NZCV flag bit positions.
package alu_issue_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LTU = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  localparam logic [1:0] COND_AL = 2'b00;
  localparam logic [1:0] COND_EQ = 2'b01;
  localparam logic [1:0] COND_CS = 2'b10;
  localparam logic [1:0] COND_LT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_issue4_core.sv
// alu4_core: purely combinational 4-bit ALU.
//   a, b      operands (two's complement)
//   op        operation select (alu_issue_pkg OP_*)
//   r         result; n/z/c/v flags derived from it
//   cv_valid  high when c/v are meaningful (add/sub only)
module alu4_core
  import alu_issue_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] r,
  output logic       n,
  output logic       z,
  output logic       c,
  output logic       v,
  output logic       cv_valid
);

  logic [4:0] s5;

  always_comb begin
    s5       = 5'b0;
    r        = 4'b0;
    c        = 1'b0;
    v        = 1'b0;
    cv_valid = 1'b0;
    case (op)
      OP_ADD: begin
        s5       = {1'b0, a} + {1'b0, b};
        r        = s5[3:0];
        c        = s5[4];
        v        = (a[3] == b[3]) && (s5[3] != a[3]);
        cv_valid = 1'b1;
      end
      OP_SUB: begin
        // 5-bit subtract: bit 4 is the borrow
        s5       = {1'b0, a} - {1'b0, b};
        r        = s5[3:0];
        c        = s5[4];
        v        = (a[3] != b[3]) && (s5[3] != a[3]);
        cv_valid = 1'b1;
      end
      OP_NOT: r = ~a;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_LTU: r = {3'b000, (a < b)};
      OP_EQ:  r = {3'b000, (a == b)};
      default: r = 4'b0;
    endcase
    n = r[3];
    z = (r == 4'b0);
  end

endmodule

// File: rtl/alu_issue4.sv
// alu_issue4: issue/control front end for the 4-bit ALU.
//   clk, rst_n (sync, active low)
//   ld_en/ld_addr/ld_data  register-file load port, IDLE only
//   in_valid/in_ready + in_op/in_cond/in_rd/in_rs/in_rt  instruction handshake
//   out_valid/out_ready + out_result/out_flags/out_skipped  registered result
// Flow: IDLE -accept-> EXEC (one cycle, writeback) -> HOLD -out_ready-> IDLE.
// NREG must stay 4: register addresses are 2 bits wide.
module alu_issue4
  import alu_issue_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [3:0] ld_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [1:0] in_cond,
  input  logic [1:0] in_rd,
  input  logic [1:0] in_rs,
  input  logic [1:0] in_rt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_result,
  output logic [3:0] out_flags,
  output logic       out_skipped
);

  state_e                 state;
  logic [NREG-1:0][3:0]   rf;
  logic [3:0]             flags;

  // instruction captured at accept; operands are values, so later
  // writes to rs/rt cannot affect it
  logic [2:0] ex_op;
  logic [1:0] ex_cond;
  logic [1:0] ex_rd;
  logic [3:0] ex_a;
  logic [3:0] ex_b;

  logic [3:0] alu_r;
  logic       alu_n, alu_z, alu_c, alu_v, alu_cv;
  logic       cond_ok;
  logic [3:0] nflags;

  assign in_ready = (state == S_IDLE) && rst_n;

  alu4_core u_core (
    .a        (ex_a),
    .b        (ex_b),
    .op       (ex_op),
    .r        (alu_r),
    .n        (alu_n),
    .z        (alu_z),
    .c        (alu_c),
    .v        (alu_v),
    .cv_valid (alu_cv)
  );

  // condition is judged against flags left by the previous instruction
  always_comb begin
    cond_ok = 1'b1;
    case (ex_cond)
      COND_AL: cond_ok = 1'b1;
      COND_EQ: cond_ok = flags[FLAG_Z];
      COND_CS: cond_ok = flags[FLAG_C];
      COND_LT: cond_ok = flags[FLAG_N] ^ flags[FLAG_V];
      default: cond_ok = 1'b1;
    endcase
  end

  // logical ops keep the prior C and V
  always_comb begin
    nflags         = flags;
    nflags[FLAG_N] = alu_n;
    nflags[FLAG_Z] = alu_z;
    if (alu_cv) begin
      nflags[FLAG_C] = alu_c;
      nflags[FLAG_V] = alu_v;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rf          <= '0;
      flags       <= 4'b0;
      ex_op       <= 3'b0;
      ex_cond     <= 2'b0;
      ex_rd       <= 2'b0;
      ex_a        <= 4'b0;
      ex_b        <= 4'b0;
      out_valid   <= 1'b0;
      out_result  <= 4'b0;
      out_flags   <= 4'b0;
      out_skipped <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_en) rf[ld_addr] <= ld_data;
          if (in_valid) begin
            // rf reads here see the pre-load value on a shared edge
            ex_op   <= in_op;
            ex_cond <= in_cond;
            ex_rd   <= in_rd;
            ex_a    <= rf[in_rs];
            ex_b    <= rf[in_rt];
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          out_valid <= 1'b1;
          state     <= S_HOLD;
          if (cond_ok) begin
            rf[ex_rd]   <= alu_r;
            flags       <= nflags;
            out_result  <= alu_r;
            out_flags   <= nflags;
            out_skipped <= 1'b0;
          end else begin
            out_result  <= 4'b0;
            out_flags   <= flags;
            out_skipped <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue4.sv
// Directed testbench for alu_issue4.
module tb_alu_issue4;
  import alu_issue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [1:0] in_cond;
  logic [1:0] in_rd, in_rs, in_rt;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic       out_skipped;

  int checks = 0;
  int failures = 0;

  alu_issue4 #(.NREG(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_cond     (in_cond),
    .in_rd       (in_rd),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .out_skipped (out_skipped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // all tasks start and end at #1 after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  // issue one instruction, check EXEC/HOLD behaviour and results,
  // optionally stall in HOLD for 'hold' cycles with a stray load pulse
  task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] cond,
                       input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt,
                       input logic [3:0] exp_r, input logic [3:0] exp_f,
                       input logic exp_skip, input int hold);
    in_valid = 1'b1; in_op = op; in_cond = cond;
    in_rd = rd; in_rs = rs; in_rt = rt;
    out_ready = 1'b0;
    chk({tag, ".rdy_idle"}, in_ready, 1);
    step();
    in_valid = 1'b0; ld_en = 1'b0;
    in_op = 3'bx; in_rd = 2'bx; in_rs = 2'bx; in_rt = 2'bx; in_cond = 2'bx;
    chk({tag, ".exec_vld"}, out_valid, 0);
    chk({tag, ".exec_rdy"}, in_ready, 0);
    step();
    chk({tag, ".vld"}, out_valid, 1);
    chk({tag, ".res"}, out_result, exp_r);
    chk({tag, ".flg"}, out_flags, exp_f);
    chk({tag, ".skip"}, out_skipped, exp_skip);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'hF; end
      else ld_en = 1'b0;
      step();
      chk({tag, ".hold_vld"}, out_valid, 1);
      chk({tag, ".hold_res"}, out_result, exp_r);
      chk({tag, ".hold_flg"}, out_flags, exp_f);
      chk({tag, ".hold_rdy"}, in_ready, 0);
    end
    ld_en = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".drain_vld"}, out_valid, 0);
    chk({tag, ".drain_rdy"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = 2'd0; ld_data = 4'd0;
    in_valid = 1'b0; in_op = 3'd0; in_cond = 2'd0;
    in_rd = 2'd0; in_rs = 2'd0; in_rt = 2'd0; out_ready = 1'b0;
    step(); step();
    chk("rst.vld", out_valid, 0);
    chk("rst.res", out_result, 0);
    chk("rst.flg", out_flags, 0);
    chk("rst.skip", out_skipped, 0);
    chk("rst.rdy", in_ready, 0);
    rst_n = 1'b1;
    step();

    // readback of r0 after reset: 0, Z only
    issue("rb_rst", OP_OR, COND_AL, 2'd0, 2'd0, 2'd0, 4'h0, 4'b0100, 1'b0, 0);

    // 7+1: signed overflow into negative
    load(2'd0, 4'd7);
    load(2'd1, 4'd1);
    issue("add", OP_ADD, COND_AL, 2'd2, 2'd0, 2'd1, 4'h8, 4'b1001, 1'b0, 0);
    issue("rb_r2", OP_OR, COND_AL, 2'd2, 2'd2, 2'd2, 4'h8, 4'b1001, 1'b0, 0);

    // 3-5 borrows; then LT (N^V=1) executes xor, C/V retained
    load(2'd0, 4'd3);
    load(2'd1, 4'd5);
    issue("sub", OP_SUB, COND_AL, 2'd2, 2'd0, 2'd1, 4'hE, 4'b1010, 1'b0, 0);
    issue("xor_lt", OP_XOR, COND_LT, 2'd3, 2'd0, 2'd0, 4'h0, 4'b0110, 1'b0, 0);

    // clear Z, then EQ-gated add is skipped and r3 keeps 7
    issue("or", OP_OR, COND_AL, 2'd3, 2'd0, 2'd1, 4'h7, 4'b0010, 1'b0, 0);
    issue("skip_eq", OP_ADD, COND_EQ, 2'd3, 2'd0, 2'd1, 4'h0, 4'b0010, 1'b1, 0);
    issue("rb_r3", OP_AND, COND_AL, 2'd3, 2'd3, 2'd3, 4'h7, 4'b0010, 1'b0, 0);

    // CS taken (C=1): 3<5 unsigned
    issue("ltu_cs", OP_LTU, COND_CS, 2'd1, 2'd0, 2'd1, 4'h1, 4'b0010, 1'b0, 0);

    // stall 5 cycles in HOLD; stray load to r0 must be ignored
    issue("hold", OP_SUB, COND_AL, 2'd1, 2'd0, 2'd0, 4'h0, 4'b0100, 1'b0, 5);
    issue("rb_r0", OP_OR, COND_AL, 2'd0, 2'd0, 2'd0, 4'h3, 4'b0000, 1'b0, 0);

    // load on the accept edge: instruction sees old r0, r0 then holds 9
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'h9;
    issue("ld_same", OP_AND, COND_AL, 2'd2, 2'd0, 2'd0, 4'h3, 4'b0000, 1'b0, 0);
    issue("rb_ld", OP_OR, COND_AL, 2'd0, 2'd0, 2'd0, 4'h9, 4'b1000, 1'b0, 0);

    // reset during EXEC discards the instruction
    load(2'd0, 4'd7);
    load(2'd1, 4'd1);
    in_valid = 1'b1; in_op = OP_ADD; in_cond = COND_AL;
    in_rd = 2'd2; in_rs = 2'd0; in_rt = 2'd1;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid_rst.vld", out_valid, 0);
    chk("mid_rst.rdy", in_ready, 0);
    chk("mid_rst.flg", out_flags, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst.novld", out_valid, 0);
    end
    issue("rb_mid_rst", OP_OR, COND_AL, 2'd2, 2'd2, 2'd2, 4'h0, 4'b0100, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute time guard so a stuck run still ends
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
